spi_rx_deser: RTL

SPI_RX_DESER -- requirements
Module: spi_rx_deser

---
 rtl/spi_rx_deser.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_rx_deser.sv
// rtl/spi_rx_deser.sv - SPI slave receive deserializer with receive FIFO and error flags.
// Optional saturating error counter on err_cnt enabled by macro SPI_RX_ERR_CNT_EN.
module spi_rx_deser #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic              clk_100,
    input  logic              s_rst,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [7:0]        err_cnt
);
    localparam int   AW          = $clog2(FIFO_DEPTH);
    localparam int   CW          = $clog2(DATA_W);
    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    // [0]/[1] are the synchronizer flops, [2] is the previous value for edge detection
    logic [2:0] sck_q, cs_q, mosi_q;
    logic [2:0] settle_q;

    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                push_q, push_d;
    logic                frame_err_q, frame_err_d;
    logic                overflow_q;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;

    logic sck_rise, sck_fall, sample_edge, cs_fall, cs_rise;
    logic pop, full, wr_en, drop;

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            sck_q    <= {3{SCK_IDLE}};
            cs_q     <= 3'b111;
            mosi_q   <= 3'b000;
            settle_q <= 3'b000;
        end else begin
            sck_q    <= {sck_q[1:0], SCK};
            cs_q     <= {cs_q[1:0], CS};
            mosi_q   <= {mosi_q[1:0], MOSI};
            settle_q <= {settle_q[1:0], 1'b1};
        end
    end

    assign sck_rise    = sck_q[1] & ~sck_q[2];
    assign sck_fall    = ~sck_q[1] & sck_q[2];
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    // A CS low left over from before reset must not look like a fresh falling edge
    assign cs_fall     = settle_q[2] & cs_q[2] & ~cs_q[1];
    assign cs_rise     = cs_q[1] & ~cs_q[2];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_q[1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        push_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
        end
    end

    // shift_q holds the completed word while push_q is high; the next sample edge is cycles away
    assign pop   = rx_valid & rx_ready;
    assign full  = (count_q == FULL_CNT);
    assign wr_en = push_q & (~full | pop);
    assign drop  = push_q & full & ~pop;

    always_ff @(posedge clk_100) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)         overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
        end
    end

    assign rx_valid  = (count_q != '0);
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

`ifdef SPI_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [8:0] err_sum;

    assign err_sum = {1'b0, err_cnt_q} + 9'(frame_err_d) + 9'(drop);

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif
endmodule
